eco_sweep_checker: RTL
======================

# eco_sweep_checker

Exhaustive stimulus sweeper and response comparator for the small gate-level ECO test circuits. It drives every combination of the two W-bit operand buses into a pair of combinational netlists: the golden netlist and the revised or ECO-patched netlist, instantiated side by side. It compares their outputs vector by vector and reports pass/fail, the mismatch count and the first failing vector. It sits directly upstream of the circuits under test (it feeds `a`/`b`) and directly downstream of them (it consumes both `y` buses).

## Interface
Parameters:
- `W`, default 3: operand and result width.
- `SETTLE`, default 0: extra wait cycles per vector before comparison. Legal range 0..15.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: begin a sweep. Sampled only in IDLE and DONE.
- `a_out`, out, W: operand a to both netlists. Registered.
- `b_out`, out, W: operand b to both netlists. Registered.
- `y_gold`, in, W: golden netlist output. Combinational from `a_out`/`b_out`.
- `y_impl`, in, W: revised netlist output. Combinational from `a_out`/`b_out`.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: sweep complete. Results valid.
- `pass`, out, 1: `done` and zero mismatches.
- `mismatch_count`, out, 2W+1: number of failing vectors. Range 0..2^(2W).
- `fail_valid`, out, 1: at least one mismatch captured.
- `fail_a`, out, W: `a_out` of the first failing vector.
- `fail_b`, out, W: `b_out` of the first failing vector.
- `fail_diff`, out, W: `y_gold ^ y_impl` at the first failing vector.

## Operation
- **Vector mapping.** Internal counter `vec` is 2W bits wide. `{a_out, b_out} = vec`, so `a_out` holds the upper bits. Sweep order is 0 up to 2^(2W)-1.
- **State machine.** States are IDLE, SETTLE, CHECK and DONE.
- **IDLE.**
  - Outputs are at their reset values.
  - `start` = 1 clears `vec`, `mismatch_count`, `fail_valid` and all `fail_*` fields.
  - The next state is SETTLE if `SETTLE` > 0, otherwise CHECK.
- **SETTLE.**
  - A wait counter loads `SETTLE`-1 on entry and decrements each cycle.
  - At 0 the state moves to CHECK.
  - `a_out`/`b_out` hold their value.
- **CHECK.** One cycle per vector. At the clock edge:
  - If `y_gold != y_impl`, `mismatch_count` increments.
  - If additionally `fail_valid` = 0, `fail_a`, `fail_b` and `fail_diff` are captured and `fail_valid` is set.
  - If `vec` equals all-ones, the state moves to DONE and `vec` holds.
  - Otherwise `vec` increments and the state moves to SETTLE (if `SETTLE` > 0) or stays in CHECK.
- **DONE.**
  - `done` = 1 and `pass` = (`mismatch_count` == 0).
  - All results hold.
  - `start` = 1 clears the results and restarts exactly as it does from IDLE.
- **`start` while busy.** `start` in SETTLE or CHECK is ignored.
- **`busy`.** Asserted in SETTLE and CHECK only.
- **`mismatch_count` width.** It is 2W+1 bits, so the all-vectors-fail case (2^(2W)) does not wrap.
- **X handling.** An X on `y_gold` or `y_impl` is not filtered. The verification bench must ensure both netlists are fully driven.

## Timing
- **Reset values.** On an edge with `rst` = 1, regardless of state:
  - state = IDLE.
  - `a_out` = `b_out` = 0.
  - `busy` = `done` = `pass` = `fail_valid` = 0.
  - `mismatch_count` = 0.
  - `fail_a` = `fail_b` = `fail_diff` = 0.
- **Reset mid-sweep.** Reset during a sweep aborts it with no partial result retained.
- **Reset priority.** `rst` has priority over `start` on the same edge.
- **Start latency.** When `start` is sampled at edge E0:
  - `busy` rises after E0.
  - `a_out`/`b_out` present vector 0 after E0.
- **Comparison point.** Comparison uses the `y` values settled during the cycle before the evaluating edge. The netlists therefore have one full cycle plus `SETTLE` cycles to settle.
- **Sweep length.** A full sweep takes N·(`SETTLE`+1) cycles, where N = 2^(2W).
  - For the defaults, N = 64 and `done` rises after edge E64.
  - On that same edge `busy` falls.
- **Result stability.** Results change only on an evaluating CHECK edge or on a clearing `start`/`rst` edge.

## Test plan
- **Reset mid-sweep.** Assert `rst` for one cycle at E10 of a sweep. Required: all outputs return to their reset values on the next edge. A fresh `start` then completes in 64 cycles.
- **Identical netlists.** `y_gold` = `y_impl` = per-bit NOR(a, b), `start` pulse, defaults. Required:
  - `busy` high for exactly 64 cycles.
  - `done` = 1, `pass` = 1, `mismatch_count` = 0, `fail_valid` = 0.
- **Stuck bit.** `y_gold` = per-bit NOR. `y_impl` equals NOR on bits 2 and 0 but has bit 1 constant 0. Required:
  - `mismatch_count` = 16, `pass` = 0.
  - `fail_a` = 3'b000, `fail_b` = 3'b000, `fail_diff` = 3'b010.
- **Every vector fails.** `y_impl` = ~`y_gold` on all bits. Required:
  - `mismatch_count` = 64, with no wrap in the 7-bit field.
  - `fail_diff` = 3'b111 and the first fail is at vector 0.
- **Settle and ignored start.** `SETTLE` = 2, with a `start` re-pulse at the 30th cycle of the sweep. Required:
  - The re-pulse is ignored.
  - `done` rises 192 cycles after the first `start`.
  - `a_out`/`b_out` change only every 3rd cycle.
- **Restart from DONE.** A second `start` issued while in DONE. Required:
  - `done`, `pass` and all `fail_*` fields clear after the start edge.
  - Vector 0 is re-driven and the sweep reruns with identical results.

Source files
------------

// File: rtl/eco_sweep_checker.sv
// eco_sweep_checker: exhaustive operand sweeper and golden-vs-revised
// response comparator for small combinational ECO test circuits.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a sweep (honoured only in IDLE and DONE)
//   a_out, b_out    operands driven to both netlists ({a_out, b_out} = vec)
//   y_gold, y_impl  netlist responses, combinational from a_out/b_out
//   busy, done      sweep in progress / sweep complete
//   pass            done with zero mismatches
//   mismatch_count  number of failing vectors (2W+1 bits, never wraps)
//   fail_valid      first failing vector has been captured
//   fail_a, fail_b  operands of the first failing vector
//   fail_diff       y_gold ^ y_impl at the first failing vector
module eco_sweep_checker #(
  parameter int unsigned W      = 3,
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  input  logic [W-1:0]     y_gold,
  input  logic [W-1:0]     y_impl,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*W:0]     mismatch_count,
  output logic             fail_valid,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [W-1:0]     fail_diff
);

  localparam int unsigned VW         = 2 * W;
  localparam int unsigned CW         = 2 * W + 1;
  localparam bit          HAS_SETTLE = (SETTLE > 0);
  localparam logic [3:0]  SETTLE_M1  = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [VW-1:0] vec, vec_d;
  logic [3:0]    wait_cnt, wait_d;
  logic [CW-1:0] count_d;
  logic          fail_valid_d;
  logic [W-1:0]  fail_a_d, fail_b_d, fail_diff_d;
  logic          busy_d, done_d, pass_d;

  logic          mism;
  logic          last_vec;

  // The operand registers are the sweep counter; a_out holds the upper half.
  assign vec      = {a_out, b_out};
  assign mism     = (y_gold != y_impl);
  assign last_vec = (vec == {VW{1'b1}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = HAS_SETTLE ? S_SETTLE : S_CHECK;
        end
      end
      S_SETTLE: begin
        if (wait_cnt == 4'd0) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (last_vec) begin
          state_next = S_DONE;
        end else begin
          state_next = HAS_SETTLE ? S_SETTLE : S_CHECK;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values; every register holds unless updated here.
  always_comb begin
    vec_d        = vec;
    wait_d       = wait_cnt;
    count_d      = mismatch_count;
    fail_valid_d = fail_valid;
    fail_a_d     = fail_a;
    fail_b_d     = fail_b;
    fail_diff_d  = fail_diff;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d        = '0;
          wait_d       = SETTLE_M1;
          count_d      = '0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_diff_d  = '0;
        end
      end
      S_SETTLE: begin
        if (wait_cnt != 4'd0) begin
          wait_d = wait_cnt - 4'd1;
        end
      end
      S_CHECK: begin
        if (mism) begin
          count_d = mismatch_count + CW'(1);
          // Only the first failing vector is recorded.
          if (!fail_valid) begin
            fail_valid_d = 1'b1;
            fail_a_d     = a_out;
            fail_b_d     = b_out;
            fail_diff_d  = y_gold ^ y_impl;
          end
        end
        if (!last_vec) begin
          vec_d  = vec + VW'(1);
          wait_d = SETTLE_M1;
        end
      end
      default: ;
    endcase

    busy_d = (state_next == S_SETTLE) || (state_next == S_CHECK);
    done_d = (state_next == S_DONE);
    pass_d = done_d && (count_d == '0);
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out          <= '0;
      b_out          <= '0;
      wait_cnt       <= '0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_a         <= '0;
      fail_b         <= '0;
      fail_diff      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      a_out          <= vec_d[VW-1:W];
      b_out          <= vec_d[W-1:0];
      wait_cnt       <= wait_d;
      mismatch_count <= count_d;
      fail_valid     <= fail_valid_d;
      fail_a         <= fail_a_d;
      fail_b         <= fail_b_d;
      fail_diff      <= fail_diff_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
    end
  end

endmodule
